// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline register bus: decode-side inputs, registered EX-side outputs,
// hazard enables and the load-use stall counter.
interface id_ex_stage_if;
    logic [4:0]  if_id_RegS;
    logic [4:0]  if_id_RegT;
    logic [4:0]  if_id_RegD;
    logic        if_id_UsesT;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] SignExt;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        MemToReg;
    logic        ALUSrc;
    logic [2:0]  ALUOp;
    logic        Flush;

    logic [4:0]  id_ex_RegS;
    logic [4:0]  id_ex_RegT;
    logic [4:0]  id_ex_RegD;
    logic [31:0] id_ex_A;
    logic [31:0] id_ex_B;
    logic [31:0] id_ex_Imm;
    logic        id_ex_RegWrite;
    logic        id_ex_MemRead;
    logic        id_ex_MemWrite;
    logic        id_ex_MemToReg;
    logic        id_ex_ALUSrc;
    logic [2:0]  id_ex_ALUOp;
    logic        id_ex_Valid;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic [15:0] StallCount;

    modport master (
        output if_id_RegS, if_id_RegT, if_id_RegD, if_id_UsesT,
        output ReadData1, ReadData2, SignExt,
        output RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, ALUOp, Flush,
        input  id_ex_RegS, id_ex_RegT, id_ex_RegD, id_ex_A, id_ex_B, id_ex_Imm,
        input  id_ex_RegWrite, id_ex_MemRead, id_ex_MemWrite, id_ex_MemToReg,
        input  id_ex_ALUSrc, id_ex_ALUOp, id_ex_Valid,
        input  PCWrite, IF_ID_Write, StallCount
    );

    modport slave (
        input  if_id_RegS, if_id_RegT, if_id_RegD, if_id_UsesT,
        input  ReadData1, ReadData2, SignExt,
        input  RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, ALUOp, Flush,
        output id_ex_RegS, id_ex_RegT, id_ex_RegD, id_ex_A, id_ex_B, id_ex_Imm,
        output id_ex_RegWrite, id_ex_MemRead, id_ex_MemWrite, id_ex_MemToReg,
        output id_ex_ALUSrc, id_ex_ALUOp, id_ex_Valid,
        output PCWrite, IF_ID_Write, StallCount
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection: a load in EX whose
// destination is read by the decoding instruction holds PC/IF-ID for one cycle.
module id_ex_stage (
    input logic         clk,
    input logic         rst,
    id_ex_stage_if.slave bus
);
    logic        loadUse;
    logic        stall;
    logic [15:0] stallCount;

    always_comb begin
        loadUse = bus.id_ex_Valid & bus.id_ex_MemRead & (bus.id_ex_RegD != 5'd0) &
                  ((bus.id_ex_RegD == bus.if_id_RegS) |
                   (bus.if_id_UsesT & (bus.id_ex_RegD == bus.if_id_RegT)));
        stall = loadUse & ~bus.Flush;
    end

    assign bus.PCWrite     = ~stall;
    assign bus.IF_ID_Write = ~stall;
    assign bus.StallCount  = stallCount;

    // Flush and stall both insert an all-zero bubble; only a true stall is counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.id_ex_RegS     <= '0;
            bus.id_ex_RegT     <= '0;
            bus.id_ex_RegD     <= '0;
            bus.id_ex_A        <= '0;
            bus.id_ex_B        <= '0;
            bus.id_ex_Imm      <= '0;
            bus.id_ex_RegWrite <= 1'b0;
            bus.id_ex_MemRead  <= 1'b0;
            bus.id_ex_MemWrite <= 1'b0;
            bus.id_ex_MemToReg <= 1'b0;
            bus.id_ex_ALUSrc   <= 1'b0;
            bus.id_ex_ALUOp    <= '0;
            bus.id_ex_Valid    <= 1'b0;
            stallCount         <= '0;
        end else begin
            if (bus.Flush || stall) begin
                bus.id_ex_RegS     <= '0;
                bus.id_ex_RegT     <= '0;
                bus.id_ex_RegD     <= '0;
                bus.id_ex_A        <= '0;
                bus.id_ex_B        <= '0;
                bus.id_ex_Imm      <= '0;
                bus.id_ex_RegWrite <= 1'b0;
                bus.id_ex_MemRead  <= 1'b0;
                bus.id_ex_MemWrite <= 1'b0;
                bus.id_ex_MemToReg <= 1'b0;
                bus.id_ex_ALUSrc   <= 1'b0;
                bus.id_ex_ALUOp    <= '0;
                bus.id_ex_Valid    <= 1'b0;
            end else begin
                bus.id_ex_RegS     <= bus.if_id_RegS;
                bus.id_ex_RegT     <= bus.if_id_RegT;
                bus.id_ex_RegD     <= bus.if_id_RegD;
                bus.id_ex_A        <= bus.ReadData1;
                bus.id_ex_B        <= bus.ReadData2;
                bus.id_ex_Imm      <= bus.SignExt;
                bus.id_ex_RegWrite <= bus.RegWrite;
                bus.id_ex_MemRead  <= bus.MemRead;
                bus.id_ex_MemWrite <= bus.MemWrite;
                bus.id_ex_MemToReg <= bus.MemToReg;
                bus.id_ex_ALUSrc   <= bus.ALUSrc;
                bus.id_ex_ALUOp    <= bus.ALUOp;
                bus.id_ex_Valid    <= 1'b1;
            end
            if (stall && (stallCount != 16'hFFFF))
                stallCount <= stallCount + 16'd1;
        end
    end
endmodule
